// File: rtl/chip_link_tx.sv
// chip_link_tx: funnels CONNECT NoC channels onto one tagged chip link with remote credit tracking.
// Define CHIP_LINK_PKT_LOCK_EN to hold the arbiter on a channel for a whole head..tail packet.
module chip_link_tx #(
  parameter int  FW           = 64,
  parameter int  B            = 4,
  parameter int  CONNECT      = 4,
  parameter int  REMOTE_DEPTH = 16,
  localparam int CW           = ($clog2(CONNECT) > 1) ? $clog2(CONNECT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CONNECT-1:0]    noc_flit_wr,
  input  logic [FW*CONNECT-1:0] noc_flit,
  output logic [CONNECT-1:0]    noc_credit,
  output logic                  link_valid,
  output logic [CW+FW-1:0]      link_data,
  input  logic                  link_stall,
  input  logic                  link_credit_valid,
  input  logic [CW-1:0]         link_credit_chan,
  output logic [CONNECT-1:0]    remote_credit_avail,
  output logic [1:0]            err
);

  localparam int         DEPTH   = 1 << B;
  localparam int         CTW     = $clog2(REMOTE_DEPTH) + 1;
  localparam logic [B:0] PTR_ONE = {{B{1'b0}}, 1'b1};

  logic [FW-1:0]      mem_r    [CONNECT][DEPTH];
  logic [B:0]         wr_ptr_r [CONNECT];
  logic [B:0]         rd_ptr_r [CONNECT];
  logic [CTW-1:0]     cnt_r    [CONNECT];
  logic [CW-1:0]      ptr_r;
  logic [1:0]         err_r;
  logic               link_valid_r;
  logic [CW+FW-1:0]   link_data_r;

  logic [CONNECT-1:0] empty_s, full_s, req_s, ret_s, cnt_full_s;
  logic [CONNECT-1:0] rr_grant_s, grant_s, wr_ok_s;
  logic [CW-1:0]      idx_s, rr_idx_s, gidx_s, ptr_next_s;
  logic [FW-1:0]      pop_flit_s;
  logic               pop_any_s, lock_next_s, advance_s, bad_chan_s, ovf_s, cred_ovf_s;
`ifdef CHIP_LINK_PKT_LOCK_EN
  logic               lock_r;
  logic [CW-1:0]      lock_chan_r, lock_chan_next_s;
`endif

  // per-channel FIFO flags, eligibility and credit-return decode
  always_comb begin
    empty_s    = '0;
    full_s     = '0;
    req_s      = '0;
    ret_s      = '0;
    cnt_full_s = '0;
    for (int i = 0; i < CONNECT; i++) begin
      empty_s[i]    = (wr_ptr_r[i] == rd_ptr_r[i]);
      full_s[i]     = (wr_ptr_r[i][B] != rd_ptr_r[i][B]) &&
                      (wr_ptr_r[i][B-1:0] == rd_ptr_r[i][B-1:0]);
      req_s[i]      = !empty_s[i] && (cnt_r[i] != '0) && !link_stall;
      ret_s[i]      = link_credit_valid && (int'(link_credit_chan) == i);
      cnt_full_s[i] = (cnt_r[i] == CTW'(REMOTE_DEPTH));
    end
    bad_chan_s = link_credit_valid && (int'(link_credit_chan) >= CONNECT);
  end

  // round-robin search from ptr; walking backwards lets the first hit win
  always_comb begin
    rr_grant_s = '0;
    rr_idx_s   = '0;
    idx_s      = '0;
    for (int k = CONNECT - 1; k >= 0; k--) begin
      idx_s = CW'((int'(ptr_r) + k) % CONNECT);
      if (req_s[idx_s]) begin
        rr_grant_s        = '0;
        rr_grant_s[idx_s] = 1'b1;
        rr_idx_s          = idx_s;
      end else begin
        rr_idx_s = rr_idx_s;
      end
    end
  end

`ifdef CHIP_LINK_PKT_LOCK_EN
  // a held lock pins the grant to its owner even when the owner cannot pop
  always_comb begin
    grant_s = '0;
    gidx_s  = rr_idx_s;
    if (lock_r) begin
      gidx_s               = lock_chan_r;
      grant_s[lock_chan_r] = req_s[lock_chan_r];
    end else begin
      grant_s = rr_grant_s;
    end
  end

  // tail releases the lock; an unterminated head takes it
  always_comb begin
    lock_next_s      = lock_r;
    lock_chan_next_s = lock_chan_r;
    if (pop_any_s && pop_flit_s[FW-2]) begin
      lock_next_s = 1'b0;
    end else if (pop_any_s && pop_flit_s[FW-1]) begin
      lock_next_s      = 1'b1;
      lock_chan_next_s = gidx_s;
    end else begin
      lock_next_s = lock_r;
    end
  end
`else
  assign grant_s     = rr_grant_s;
  assign gidx_s      = rr_idx_s;
  assign lock_next_s = 1'b0;
`endif

  assign pop_any_s  = |grant_s;
  assign pop_flit_s = mem_r[gidx_s][rd_ptr_r[gidx_s][B-1:0]];
  assign advance_s  = pop_any_s && !lock_next_s;
  assign ptr_next_s = (gidx_s == CW'(CONNECT - 1)) ? '0 : gidx_s + CW'(1);
  // a pop in the same cycle frees the slot a full-FIFO write needs
  assign wr_ok_s    = noc_flit_wr & (~full_s | grant_s);
  assign ovf_s      = |(noc_flit_wr & full_s & ~grant_s);
  assign cred_ovf_s = |(ret_s & cnt_full_s & ~grant_s);

  assign noc_credit = grant_s;
  assign link_valid = link_valid_r;
  assign link_data  = link_data_r;
  assign err        = err_r;

  // remote credit availability straight from the counters
  always_comb begin
    remote_credit_avail = '0;
    for (int i = 0; i < CONNECT; i++) begin
      remote_credit_avail[i] = (cnt_r[i] != '0);
    end
  end

  // flit storage; contents only matter between the pointers
  always_ff @(posedge clk) begin
    for (int i = 0; i < CONNECT; i++) begin
      if (wr_ok_s[i]) mem_r[i][wr_ptr_r[i][B-1:0]] <= noc_flit[FW*i +: FW];
    end
  end

  // pointers, credit counters, arbitration state, sticky errors and link register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CONNECT; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        cnt_r[i]    <= CTW'(REMOTE_DEPTH);
      end
      ptr_r        <= '0;
      err_r        <= 2'b00;
      link_valid_r <= 1'b0;
      link_data_r  <= '0;
`ifdef CHIP_LINK_PKT_LOCK_EN
      lock_r       <= 1'b0;
      lock_chan_r  <= '0;
`endif
    end else begin
      for (int i = 0; i < CONNECT; i++) begin
        if (wr_ok_s[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_ONE;
        if (grant_s[i]) rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
        case ({grant_s[i], ret_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] - CTW'(1);
          2'b01:   cnt_r[i] <= cnt_full_s[i] ? cnt_r[i] : cnt_r[i] + CTW'(1);
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
      if (advance_s) ptr_r <= ptr_next_s;
      err_r[0]     <= err_r[0] | ovf_s;
      err_r[1]     <= err_r[1] | bad_chan_s | cred_ovf_s;
      link_valid_r <= pop_any_s;
      if (pop_any_s) link_data_r <= {gidx_s, pop_flit_s};
`ifdef CHIP_LINK_PKT_LOCK_EN
      lock_r       <= lock_next_s;
      lock_chan_r  <= lock_chan_next_s;
`endif
    end
  end

endmodule
